// File: rtl/quad_chain_ctrl.sv
// Sequencer for the GF(2^233) repeated-squaring datapath: computes operand^(2^count)
// by chaining up to STEP_MAX squarings per clock through an external quad_block.
module quad_chain_ctrl #(
  parameter int unsigned WIDTH    = 233,
  parameter int unsigned STEP_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] q_in,
  output logic [3:0]       q_sel,
  output logic [1:0]       q_enable,
  input  logic [WIDTH-1:0] q_out
);

  localparam int unsigned SEL_W = 4;
  localparam logic [CNT_W-1:0] STEP_MAX_CNT = CNT_W'(STEP_MAX);
  localparam logic [1:0] Q_EN_RUN  = 2'b01;
  localparam logic [1:0] Q_EN_IDLE = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   q_sel_q, q_sel_d;
  logic [1:0]         q_en_q, q_en_d;

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      q_sel_q  <= '0;
      q_en_q   <= Q_EN_IDLE;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      q_sel_q  <= q_sel_d;
      q_en_q   <= q_en_d;
    end
  end

  // Next-state and accumulator update; q_sel_q already holds min(rem_q, STEP_MAX) in RUN
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = operand;
          rem_d   = count;
          state_d = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d   = q_out;
        rem_d   = rem_q - CNT_W'(q_sel_q);
        state_d = (rem_q == CNT_W'(q_sel_q)) ? DONE : RUN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register inputs, derived from the upcoming state so outputs align with it
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    result_d = result_q;
    q_sel_d  = '0;
    q_en_d   = Q_EN_IDLE;
    if (state_d == DONE && state_q != DONE) begin
      result_d = acc_d;
    end
    if (state_d == RUN) begin
      q_en_d  = Q_EN_RUN;
      q_sel_d = (rem_d > STEP_MAX_CNT) ? SEL_W'(STEP_MAX) : SEL_W'(rem_d);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign q_in     = acc_q;
  assign q_sel    = q_sel_q;
  assign q_enable = q_en_q;

endmodule

// File: doc/quad_chain_ctrl.md
Name: quad_chain_ctrl

Overview:
- Sequencer for the GF(2^233) repeated-squaring datapath (`quad_block`).
- Computes result = operand^(2^count) by chaining passes through the combinational quad datapath, one pass per clock.
- Each pass applies up to STEP_MAX squarings, selected via q_sel.
- Sits between the inversion/point-arithmetic scheduler (start/done handshake) and the `quad_block_top` instance (q_in/q_sel/q_enable out, q_out in).

Parameters:
- WIDTH, 233, field element width (GF(2^233), reduction polynomial x^233+x^74+1).
- STEP_MAX, 15, maximum squarings per pass; legal 1..15 (fits 4-bit sel).
- CNT_W, 8, width of count input.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- operand  input  WIDTH  field element, latched on accepted start.
- count  input  CNT_W  total squarings to apply; latched on accepted start.
- busy  output  1  high from the cycle after accepted start until done is asserted, inclusive.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  WIDTH  final value, held until the next accepted start.
- q_in  output  WIDTH  datapath operand (driven from accumulator register).
- q_sel  output  4  squarings for current pass; sel=k means q_out = q_in^(2^k).
- q_enable  output  2  2'b01 during RUN passes, 2'b00 otherwise.
- q_out  input  WIDTH  combinational datapath result for current q_in/q_sel.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; acc=0; remaining=0; result=0; busy=0; done=0; q_sel=0; q_enable=2'b00.
  - Applies mid-operation: the run is abandoned and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: acc<=operand, remaining<=count, busy<=1.
  - Next state is DONE if count==0, else RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - step=min(remaining, STEP_MAX); q_sel=step; q_in=acc; q_enable=2'b01.
  - At the edge: acc<=q_out, remaining<=remaining-step.
  - If remaining==step, next state is DONE; otherwise stay in RUN.
- DONE (one cycle):
  - result=acc, registered on entry so it is visible in this cycle.
  - done=1, busy=1, q_enable=2'b00, q_sel=0.
  - Next state is IDLE; busy=0 from the IDLE cycle onward.
- Latency: start edge to done-high cycle = ceil(count/STEP_MAX)+1 cycles; count=0 gives 1 cycle.
- start is ignored while busy=1; latched operands never change mid-run.
- start asserted in the cycle done is high is ignored (state is DONE). It is accepted only in the following IDLE cycle.
- count>233 is legal and is not clamped; the sequencer executes all passes. Bench note: 233 squarings is the identity in GF(2^233).
- q_sel is never 0 while q_enable=2'b01.
- remaining never underflows.
- Outside RUN, q_in holds acc (no glitch requirement).
- result changes only on DONE entry or reset.

Test Plan:
The bench supplies a behavioural squaring model for q_out (poly x^233+x^74+1).
1. Reset check: assert rst_n=0 for 2 cycles -> result=0, busy=0, done=0, q_enable=2'b00.
2. count=0, operand=0x1234 -> done exactly 1 cycle after start; result=0x1234; q_enable never 2'b01.
3. STEP_MAX=15, operand=x (bit1 set), count=3 -> one pass with q_sel=3; done at start+2; result has only bit8 set.
4. STEP_MAX=4, operand=x, count=7 -> passes q_sel=4 then q_sel=3; done at start+3; result has only bit128 set.
5. STEP_MAX=15, operand=1, count=30 -> q_sel sequence 15,15; result=1. A second start pulsed mid-run is ignored (no extra done, result unchanged).
6. Reset mid-run: count=60, rst_n=0 after 2 passes -> next cycle IDLE, busy=0, result=0, no done pulse. A new start with count=1, operand=x then yields result bit2 set.
